hazard_sequencer: RTL and testbench

- Pipeline sequencing controller for the 5-stage MIPS core. Sits beside the main opcode decoder.
- Watches the ID and EX stages and the data-memory ready line.
- Drives PC write-enable, IF/ID write/flush, ID/EX bubble insertion and EX/MEM hold.
- Registered state machine with cycle counters. Outputs are Mealy: combinational from the current state and inputs, so stalls take effect in the same cycle.

---
 rtl/hazard_sequencer.sv | 169 ++++++++++++++++
 tb/tb_hazard_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_sequencer.sv
// Pipeline sequencing controller: load-use stalls, branch/jump flushes and memory-wait holds.
// Optional cycle counters (stall_cycles, flush_cycles) are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_sequencer #(
    parameter int unsigned LOAD_USE_CYCLES = 1,
    parameter int unsigned FLUSH_CYCLES    = 1,
    parameter int unsigned CNT_W           = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] id_opcode,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic       ex_branch_taken,
    input  logic       id_jump,
    input  logic       mem_busy,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       ifid_flush,
    output logic       idex_bubble,
    output logic       exmem_hold,
    output logic [1:0] state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_cycles
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_LU_STALL = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] LU_RELOAD    = CNT_W'(LOAD_USE_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rt_use_s;
    logic             load_use_s;

    // State and down-counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Hazard detection, next-state and Mealy outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_hold  = 1'b0;

        rt_use_s   = (id_opcode == 6'd0) || (id_opcode == 6'd4) || (id_opcode == 6'd43);
        load_use_s = ex_mem_read && (ex_rt != 5'd0) &&
                     ((ex_rt == id_rs) || (rt_use_s && (ex_rt == id_rt)));

        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (mem_busy) begin
            // A busy memory freezes every state; counters hold their value.
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            exmem_hold = 1'b1;
            if ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) begin
                state_d = ST_MEM_WAIT;
            end else begin
                state_d = state_q;
            end
        end else begin
            case (state_q)
                ST_RUN, ST_MEM_WAIT: begin
                    state_d = ST_RUN;
                    if (ex_branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            cnt_d   = FLUSH_RELOAD;
                            state_d = ST_FLUSH;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else if (load_use_s) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        if (LOAD_USE_CYCLES > 1) begin
                            cnt_d   = LU_RELOAD;
                            state_d = ST_LU_STALL;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else if (id_jump) begin
                        ifid_flush = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_LU_STALL: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    cnt_d       = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_LU_STALL;
                    end
                end
                ST_FLUSH: begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    cnt_d       = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign state = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_q, flush_q;

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 32'd0;
            flush_q <= 32'd0;
        end else begin
            if (!pc_write && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (ifid_flush && (flush_q != 32'hFFFF_FFFF)) begin
                flush_q <= flush_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_cycles = flush_q;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: default-parameter instance (a) and LOAD_USE_CYCLES=3/FLUSH_CYCLES=2 instance (b) share stimulus.
module tb_hazard_sequencer;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       mr;
        logic [4:0] ert;
        logic       br;
        logic       jmp;
        logic       busy;
        logic [6:0] exp_a;
        logic [6:0] exp_b;
    } vec_t;

    // {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold}
    localparam logic [4:0] O_NORM = 5'b11000;
    localparam logic [4:0] O_HOLD = 5'b00001;
    localparam logic [4:0] O_RST  = 5'b00110;
    localparam logic [4:0] O_BR   = 5'b11110;
    localparam logic [4:0] O_LU   = 5'b00010;
    localparam logic [4:0] O_JMP  = 5'b11100;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] id_opcode;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       ex_mem_read, ex_branch_taken, id_jump, mem_busy;
    logic       pc_write_a, ifid_write_a, ifid_flush_a, idex_bubble_a, exmem_hold_a;
    logic       pc_write_b, ifid_write_b, ifid_flush_b, idex_bubble_b, exmem_hold_b;
    logic [1:0] state_a, state_b;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_a, flush_a, stall_b, flush_b;
`endif

    int num_checks = 0;
    int num_errors = 0;
    logic [13:0] exp_q[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    hazard_sequencer dut_a (
        .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .id_jump(id_jump), .mem_busy(mem_busy), .pc_write(pc_write_a),
        .ifid_write(ifid_write_a), .ifid_flush(ifid_flush_a), .idex_bubble(idex_bubble_a),
        .exmem_hold(exmem_hold_a), .state(state_a)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(stall_a), .flush_cycles(flush_a)
`endif
    );

    hazard_sequencer #(.LOAD_USE_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .id_jump(id_jump), .mem_busy(mem_busy), .pc_write(pc_write_b),
        .ifid_write(ifid_write_b), .ifid_flush(ifid_flush_b), .idex_bubble(idex_bubble_b),
        .exmem_hold(exmem_hold_b), .state(state_b)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(stall_b), .flush_cycles(flush_b)
`endif
    );

    function automatic vec_t mk(input logic r, input logic [5:0] op, input logic [4:0] rs,
                                input logic [4:0] rt, input logic mr, input logic [4:0] ert,
                                input logic br, input logic j, input logic busy,
                                input logic [4:0] oa, input logic [1:0] sa,
                                input logic [4:0] ob, input logic [1:0] sb);
        vec_t v;
        v.rst = r; v.op = op; v.rs = rs; v.rt = rt; v.mr = mr; v.ert = ert;
        v.br = br; v.jmp = j; v.busy = busy;
        v.exp_a = {oa, sa};
        v.exp_b = {ob, sb};
        return v;
    endfunction

    function automatic vec_t idle(input logic [4:0] oa, input logic [1:0] sa,
                                  input logic [4:0] ob, input logic [1:0] sb);
        return mk(1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, oa, sa, ob, sb);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        logic [13:0] e;
        @(posedge clk);
        #1;
        rst = v.rst; id_opcode = v.op; id_rs = v.rs; id_rt = v.rt;
        ex_mem_read = v.mr; ex_rt = v.ert; ex_branch_taken = v.br;
        id_jump = v.jmp; mem_busy = v.busy;
        exp_q.push_back({v.exp_a, v.exp_b});
        @(negedge clk);
        e = exp_q.pop_front();
        check({name, "/a"}, {25'd0, pc_write_a, ifid_write_a, ifid_flush_a, idex_bubble_a,
                             exmem_hold_a, state_a}, {25'd0, e[13:7]});
        check({name, "/b"}, {25'd0, pc_write_b, ifid_write_b, ifid_flush_b, idex_bubble_b,
                             exmem_hold_b, state_b}, {25'd0, e[6:0]});
    endtask

    initial begin
        rst = 1'b1; id_opcode = 6'd0; id_rs = 5'd0; id_rt = 5'd0; ex_mem_read = 1'b0;
        ex_rt = 5'd0; ex_branch_taken = 1'b0; id_jump = 1'b0; mem_busy = 1'b0;

        // reset, then rt load-use (b stalls 3 cycles)
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, O_RST, 2'd0, O_RST, 2'd0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, O_RST, 2'd0, O_RST, 2'd0));
        vecs.push_back(idle(O_NORM, 2'd0, O_NORM, 2'd0));
        vecs.push_back(mk(0, 0, 1, 5, 1, 5, 0, 0, 0, O_LU, 2'd0, O_LU, 2'd0));
        vecs.push_back(idle(O_NORM, 2'd0, O_LU, 2'd3));
        vecs.push_back(idle(O_NORM, 2'd0, O_LU, 2'd3));
        vecs.push_back(idle(O_NORM, 2'd0, O_NORM, 2'd0));
        // lw does not read rt; ex_rt==0 never stalls
        vecs.push_back(mk(0, 35, 1, 5, 1, 5, 0, 0, 0, O_NORM, 2'd0, O_NORM, 2'd0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, O_NORM, 2'd0, O_NORM, 2'd0));
        // rs hazard, then mem_busy for 4 cycles in the middle of b's stall
        vecs.push_back(mk(0, 35, 7, 0, 1, 7, 0, 0, 0, O_LU, 2'd0, O_LU, 2'd0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, O_HOLD, 2'd0, O_HOLD, 2'd3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, O_HOLD, 2'd1, O_HOLD, 2'd3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, O_HOLD, 2'd1, O_HOLD, 2'd3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, O_HOLD, 2'd1, O_HOLD, 2'd3));
        vecs.push_back(idle(O_NORM, 2'd1, O_LU, 2'd3));
        vecs.push_back(idle(O_NORM, 2'd0, O_LU, 2'd3));
        vecs.push_back(idle(O_NORM, 2'd0, O_NORM, 2'd0));
        // branch beats load-use; b flushes 2 cycles
        vecs.push_back(mk(0, 0, 3, 0, 1, 3, 1, 0, 0, O_BR, 2'd0, O_BR, 2'd0));
        vecs.push_back(idle(O_NORM, 2'd0, O_BR, 2'd2));
        vecs.push_back(idle(O_NORM, 2'd0, O_NORM, 2'd0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_JMP, 2'd0, O_JMP, 2'd0));
        // reset during FLUSH
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_BR, 2'd0, O_BR, 2'd0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, O_RST, 2'd0, O_RST, 2'd2));
        vecs.push_back(idle(O_NORM, 2'd0, O_NORM, 2'd0));
        // MEM_WAIT releasing straight into a branch
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, O_HOLD, 2'd0, O_HOLD, 2'd0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_BR, 2'd1, O_BR, 2'd1));
        vecs.push_back(idle(O_NORM, 2'd0, O_BR, 2'd2));
        vecs.push_back(idle(O_NORM, 2'd0, O_NORM, 2'd0));
        // branch and jump ignored during LU_STALL
        vecs.push_back(mk(0, 35, 7, 0, 1, 7, 0, 0, 0, O_LU, 2'd0, O_LU, 2'd0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, O_BR, 2'd0, O_LU, 2'd3));
        vecs.push_back(idle(O_NORM, 2'd0, O_LU, 2'd3));
        vecs.push_back(idle(O_NORM, 2'd0, O_NORM, 2'd0));
        // mem_busy during FLUSH freezes the counter
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_BR, 2'd0, O_BR, 2'd0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, O_HOLD, 2'd0, O_HOLD, 2'd2));
        vecs.push_back(idle(O_NORM, 2'd1, O_BR, 2'd2));
        vecs.push_back(idle(O_NORM, 2'd0, O_NORM, 2'd0));
        // sw and beq read rt; j does not; no load means no stall
        vecs.push_back(mk(0, 43, 0, 9, 1, 9, 0, 0, 0, O_LU, 2'd0, O_LU, 2'd0));
        vecs.push_back(idle(O_NORM, 2'd0, O_LU, 2'd3));
        vecs.push_back(idle(O_NORM, 2'd0, O_LU, 2'd3));
        vecs.push_back(mk(0, 4, 0, 9, 1, 9, 0, 0, 0, O_LU, 2'd0, O_LU, 2'd0));
        vecs.push_back(idle(O_NORM, 2'd0, O_LU, 2'd3));
        vecs.push_back(idle(O_NORM, 2'd0, O_LU, 2'd3));
        vecs.push_back(mk(0, 2, 0, 9, 1, 9, 0, 0, 0, O_NORM, 2'd0, O_NORM, 2'd0));
        vecs.push_back(mk(0, 0, 9, 9, 0, 9, 0, 0, 0, O_NORM, 2'd0, O_NORM, 2'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // reset aborting a load-use stall
        apply(mk(0, 35, 7, 0, 1, 7, 0, 0, 0, O_LU, 2'd0, O_LU, 2'd0), "lu_rst0");
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, O_RST, 2'd0, O_RST, 2'd3), "lu_rst1");
        apply(idle(O_NORM, 2'd0, O_NORM, 2'd0), "lu_rst2");

        // load stall plus one jump, for the cycle counters
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, O_RST, 2'd0, O_RST, 2'd0), "perf0");
        apply(mk(0, 35, 7, 0, 1, 7, 0, 0, 0, O_LU, 2'd0, O_LU, 2'd0), "perf1");
        apply(idle(O_NORM, 2'd0, O_LU, 2'd3), "perf2");
        apply(idle(O_NORM, 2'd0, O_LU, 2'd3), "perf3");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_JMP, 2'd0, O_JMP, 2'd0), "perf4");
        apply(idle(O_NORM, 2'd0, O_NORM, 2'd0), "perf5");
`ifdef HAZARD_PERF_CNT_EN
        check("stall_a", stall_a, 32'd1);
        check("flush_a", flush_a, 32'd1);
        check("stall_b", stall_b, 32'd3);
        check("flush_b", flush_b, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
